// File: rtl/led_matrix_scan_ctrl_if.sv
// Frame-buffer read port between the scan controller and the pixel store.
// The controller strobes fb_rd_en with a row address; the row's 24-bit
// {r,g,b} word is valid on fb_rdata one cycle later.
interface led_matrix_scan_ctrl_if;
    logic        fb_rd_en;
    logic [2:0]  fb_raddr;
    logic [23:0] fb_rdata;

    modport master (
        output fb_rd_en,
        output fb_raddr,
        input  fb_rdata
    );

    modport slave (
        input  fb_rd_en,
        input  fb_raddr,
        output fb_rdata
    );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan sequencer for the 8x8 RGB LED matrix. Each scan slot fetches one
// row from the frame buffer, blanks all lines to avoid ghosting, then drives
// the row with PWM columns gated by a latched global brightness. Global
// brightness is either fixed_brightness or a free-running triangle ramp.
module led_matrix_scan_ctrl #(
    parameter int PWM_DIV    = 4,
    parameter int BLANK_CYC  = 16,
    parameter int BREATH_DIV = 196078
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   breath_en,
    input  logic [7:0]             fixed_brightness,
    led_matrix_scan_ctrl_if.master fb,
    output logic [7:0]             led_row,
    output logic [7:0]             led_col_r,
    output logic [7:0]             led_col_g,
    output logic [7:0]             led_col_b,
    output logic [2:0]             row_idx,
    output logic [7:0]             global_brightness,
    output logic                   frame_done
);

    localparam int PWM_W    = (PWM_DIV    > 1) ? $clog2(PWM_DIV)    : 1;
    localparam int BLANK_W  = (BLANK_CYC  > 1) ? $clog2(BLANK_CYC)  : 1;
    localparam int BREATH_W = (BREATH_DIV > 1) ? $clog2(BREATH_DIV) : 1;

    localparam logic [PWM_W-1:0]    DIV_LAST    = PWM_W'(PWM_DIV - 1);
    localparam logic [BLANK_W-1:0]  BLANK_LAST  = BLANK_W'(BLANK_CYC - 1);
    localparam logic [BREATH_W-1:0] BREATH_LAST = BREATH_W'(BREATH_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH1,   // read strobe out
        S_FETCH2,   // read data returns, latched at the end of this cycle
        S_BLANK,
        S_DRIVE
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // Scan sequencer state
    state_t              state, state_d;
    logic [2:0]          row_d;
    logic [BLANK_W-1:0]  blank_cnt, blank_d;
    logic [PWM_W-1:0]    div_cnt, div_d;
    logic [7:0]          pwm_cnt, pwm_d;
    logic [23:0]         pix;
    logic [7:0]          bright_l;

    // Registered output next-values
    logic                rd_en_q, rd_en_d;
    logic [7:0]          row_sel_d;
    logic [7:0]          col_r_d, col_g_d, col_b_d;
    logic                frame_done_d;
    logic                lit;

    // Breathing ramp state
    logic [BREATH_W-1:0] breath_cnt, breath_cnt_d;
    logic [7:0]          level, level_d;
    dir_t                dir, dir_d;

    assign fb.fb_rd_en = rd_en_q;
    assign fb.fb_raddr = row_idx;

    // Scan state, counters, latched row data and registered pin outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            row_idx    <= '0;
            blank_cnt  <= '0;
            div_cnt    <= '0;
            pwm_cnt    <= '0;
            pix        <= '0;
            bright_l   <= '0;
            rd_en_q    <= 1'b0;
            led_row    <= '0;
            led_col_r  <= 8'hFF;
            led_col_g  <= 8'hFF;
            led_col_b  <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values,
            // independent of statement order.
            state      <= state_d;
            row_idx    <= row_d;
            blank_cnt  <= blank_d;
            div_cnt    <= div_d;
            pwm_cnt    <= pwm_d;
            if (state == S_FETCH2 && state_d == S_BLANK) begin
                pix      <= fb.fb_rdata;
                bright_l <= global_brightness;
            end
            rd_en_q    <= rd_en_d;
            led_row    <= row_sel_d;
            led_col_r  <= col_r_d;
            led_col_g  <= col_g_d;
            led_col_b  <= col_b_d;
            frame_done <= frame_done_d;
        end
    end

    // Next scan state and counter values; enable=0 forces IDLE from anywhere.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state;
        row_d   = row_idx;
        blank_d = blank_cnt;
        div_d   = div_cnt;
        pwm_d   = pwm_cnt;
        if (!enable) begin
            state_d = S_IDLE;
            row_d   = '0;
            blank_d = '0;
            div_d   = '0;
            pwm_d   = '0;
        end else begin
            unique case (state)
                S_IDLE:   state_d = S_FETCH1;
                S_FETCH1: state_d = S_FETCH2;
                S_FETCH2: begin
                    state_d = S_BLANK;
                    blank_d = '0;
                end
                S_BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state_d = S_DRIVE;
                        div_d   = '0;
                        pwm_d   = '0;
                    end else begin
                        blank_d = blank_cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (div_cnt == DIV_LAST) begin
                        div_d = '0;
                        if (pwm_cnt == 8'hFF) begin
                            // Row finished: next slot fetches the following row.
                            state_d = S_FETCH1;
                            row_d   = row_idx + 3'd1;
                            pwm_d   = '0;
                        end else begin
                            pwm_d = pwm_cnt + 8'd1;
                        end
                    end else begin
                        div_d = div_cnt + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pin values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        rd_en_d      = (state_d == S_FETCH1);
        row_sel_d    = '0;
        col_r_d      = 8'hFF;
        col_g_d      = 8'hFF;
        col_b_d      = 8'hFF;
        frame_done_d = 1'b0;
        lit          = (pwm_d < bright_l);
        if (state_d == S_DRIVE) begin
            row_sel_d    = 8'b1 << row_d;
            col_r_d      = ~(pix[23:16] & {8{lit}});
            col_g_d      = ~(pix[15:8]  & {8{lit}});
            col_b_d      = ~(pix[7:0]   & {8{lit}});
            frame_done_d = (pwm_d == 8'hFF) && (div_d == DIV_LAST) && (row_d == 3'd7);
        end
    end

    // Triangle ramp step; divider and level hold while breath_en=0.
    always_comb begin
        breath_cnt_d = breath_cnt;
        level_d      = level;
        dir_d        = dir;
        if (breath_en) begin
            if (breath_cnt == BREATH_LAST) begin
                breath_cnt_d = '0;
                if (dir == DIR_UP) begin
                    if (level == 8'hFF) begin
                        dir_d   = DIR_DOWN;
                        level_d = 8'hFE;
                    end else begin
                        level_d = level + 8'd1;
                    end
                end else begin
                    if (level == 8'h00) begin
                        dir_d   = DIR_UP;
                        level_d = 8'h01;
                    end else begin
                        level_d = level - 8'd1;
                    end
                end
            end else begin
                breath_cnt_d = breath_cnt + 1'b1;
            end
        end
    end

    // Breathing registers and the effective brightness, independent of enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            breath_cnt        <= '0;
            level             <= '0;
            dir               <= DIR_UP;
            global_brightness <= '0;
        end else begin
            breath_cnt        <= breath_cnt_d;
            level             <= level_d;
            dir               <= dir_d;
            global_brightness <= breath_en ? level_d : fixed_brightness;
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl. A frame-buffer model pushes
// the expected row (address, pixel word, brightness to be latched) onto a
// scoreboard when a fetch is served; the drive phase pops it and checks
// every DRIVE cycle, plus blanking gaps, resets, enable drop and breathing.
module tb_led_matrix_scan_ctrl;

    localparam int PWM_DIV    = 1;
    localparam int BLANK_CYC  = 4;
    localparam int BREATH_DIV = 2;
    localparam int GAP        = BLANK_CYC + 2;
    localparam int DRIVE_CYC  = 256 * PWM_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       breath_en = 1'b0;
    logic [7:0] fixed_brightness = 8'd0;
    logic [7:0] led_row, led_col_r, led_col_g, led_col_b;
    logic [2:0] row_idx;
    logic [7:0] global_brightness;
    logic       frame_done;

    led_matrix_scan_ctrl_if fb ();

    led_matrix_scan_ctrl #(
        .PWM_DIV    (PWM_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .BREATH_DIV (BREATH_DIV)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .breath_en         (breath_en),
        .fixed_brightness  (fixed_brightness),
        .fb                (fb),
        .led_row           (led_row),
        .led_col_r         (led_col_r),
        .led_col_g         (led_col_g),
        .led_col_b         (led_col_b),
        .row_idx           (row_idx),
        .global_brightness (global_brightness),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame buffer contents and read model (data one cycle after strobe).
    logic [23:0] mem [8];

    always @(posedge clk or negedge rst) begin
        if (!rst)            fb.fb_rdata <= '0;
        else if (fb.fb_rd_en) fb.fb_rdata <= mem[fb.fb_raddr];
    end

    // Brightness reference: triangle ramp or registered fixed value.
    function automatic logic [8:0] breath_step(input logic down, input logic [7:0] b);
        if (!down) return (b == 8'd255) ? {1'b1, 8'd254} : {1'b0, b + 8'd1};
        else       return (b == 8'd0)   ? {1'b0, 8'd1}   : {1'b1, b - 8'd1};
    endfunction

    logic [7:0] m_b, m_gb;
    logic       m_down;
    int         m_div;
    logic [8:0] m_stepped;
    logic       m_wrap;

    assign m_stepped = breath_step(m_down, m_b);
    assign m_wrap    = (m_div == BREATH_DIV - 1);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_b    <= '0;
            m_down <= 1'b0;
            m_div  <= 0;
            m_gb   <= '0;
        end else if (breath_en) begin
            m_div <= m_wrap ? 0 : m_div + 1;
            if (m_wrap) {m_down, m_b} <= m_stepped;
            m_gb <= m_wrap ? m_stepped[7:0] : m_b;
        end else begin
            m_gb <= fixed_brightness;
        end
    end

    // Scoreboard: push the expected row when the fetched data is presented.
    typedef struct packed {
        logic [2:0]  addr;
        logic [23:0] data;
        logic [7:0]  bright;
    } row_exp_t;

    row_exp_t   sb[$];
    logic       fetch_prev = 1'b0;
    logic [2:0] fetch_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            fetch_prev <= 1'b0;
        end else begin
            if (fetch_prev)
                sb.push_back('{addr: fetch_addr, data: mem[fetch_addr], bright: m_gb});
            fetch_prev <= fb.fb_rd_en;
            fetch_addr <= fb.fb_raddr;
        end
    end

    int exp_row = 0;

    // Check n complete rows: start, every DRIVE cycle, then the blanking gap.
    task automatic run_rows(input int n);
        row_exp_t   e;
        logic [7:0] m;
        logic [7:0] sel;
        logic       fd;
        int         waited;
        int         gap;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            sel = 8'h01 << exp_row[2:0];
            while (led_row == 8'h00 && waited < 400) begin
                @(negedge clk);
                waited++;
            end
            check("row_start", led_row, sel);
            if (led_row == 8'h00) return;
            check("sb_pending", sb.size(), 1);
            if (sb.size() == 0) return;
            e = sb.pop_front();
            check("fb_raddr", e.addr, exp_row[2:0]);
            for (int k = 0; k < DRIVE_CYC; k++) begin
                m  = ((k / PWM_DIV) < e.bright) ? 8'hFF : 8'h00;
                fd = (exp_row == 7) && (k == DRIVE_CYC - 1);
                check($sformatf("drive row%0d k%0d", exp_row, k),
                      {frame_done, row_idx, led_row, led_col_r, led_col_g, led_col_b},
                      {fd, exp_row[2:0], sel, ~(e.data[23:16] & m), ~(e.data[15:8] & m), ~(e.data[7:0] & m)});
                @(negedge clk);
            end
            gap = 0;
            while (led_row == 8'h00 && gap < 40) begin
                check("gap_off", {frame_done, led_col_r, led_col_g, led_col_b}, {1'b0, 24'hFFFFFF});
                @(negedge clk);
                gap++;
            end
            check("row_gap", gap, GAP);
            exp_row = (exp_row + 1) % 8;
        end
    endtask

    // Restart scanning from IDLE with a fresh scoreboard.
    task automatic restart_scan();
        enable = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        exp_row = 0;
        enable = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    int cp_edge [6] = '{1, 2, 510, 512, 1020, 1022};
    int cp_val  [6] = '{0, 1, 255, 254, 0, 1};
    int edge_n;
    row_exp_t abort_e;

    initial begin
        mem[0] = 24'hA5_00_FF; mem[1] = 24'h3C_C3_81;
        mem[2] = 24'h0F_F0_55; mem[3] = 24'h80_01_AA;
        mem[4] = 24'hFF_FF_FF; mem[5] = 24'h00_00_00;
        mem[6] = 24'h12_34_56; mem[7] = 24'hE7_18_7E;

        // Reset values while held.
        fixed_brightness = 8'd128;
        repeat (3) @(negedge clk);
        check("rst_hold",
              {led_row, led_col_r, led_col_g, led_col_b, fb.fb_rd_en, fb.fb_raddr, row_idx, frame_done, global_brightness},
              {8'h00, 24'hFFFFFF, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0});

        // Fixed 128: full frame plus wrap back to row 0.
        sb.delete();
        exp_row = 0;
        rst = 1'b1;
        enable = 1'b1;
        run_rows(9);

        // Brightness extremes.
        fixed_brightness = 8'd0;
        restart_scan();
        run_rows(1);
        fixed_brightness = 8'd255;
        restart_scan();
        run_rows(1);

        // Asynchronous reset in the middle of DRIVE.
        fixed_brightness = 8'd128;
        restart_scan();
        run_rows(2);
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst",
              {led_row, led_col_r, led_col_g, led_col_b, fb.fb_rd_en, row_idx, frame_done, global_brightness},
              {8'h00, 24'hFFFFFF, 1'b0, 3'd0, 1'b0, 8'd0});
        @(negedge clk);
        sb.delete();
        exp_row = 0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_first_fetch", {fb.fb_rd_en, fb.fb_raddr}, {1'b1, 3'd0});
        run_rows(1);

        // Breathing from reset, then latched brightness across rows.
        enable = 1'b0;
        breath_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        sb.delete();
        rst = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 6; i++) begin
            while (edge_n < cp_edge[i]) begin
                @(posedge clk);
                edge_n++;
            end
            @(negedge clk);
            check($sformatf("breath_e%0d", cp_edge[i]), global_brightness, cp_val[i]);
        end
        exp_row = 0;
        enable = 1'b1;
        run_rows(2);

        // Freeze with a fixed value, then resume from the frozen ramp.
        breath_en = 1'b0;
        fixed_brightness = 8'd77;
        @(negedge clk);
        check("freeze_fixed", global_brightness, 8'd77);
        repeat (20) @(negedge clk);
        breath_en = 1'b1;
        @(negedge clk);
        check("breath_resume", global_brightness, m_gb);
        repeat (7) @(negedge clk);
        check("breath_resume_7", global_brightness, m_gb);

        // Enable dropped mid-DRIVE of row 3, then restart at row 0.
        breath_en = 1'b0;
        fixed_brightness = 8'd200;
        restart_scan();
        run_rows(3);
        check("abort_row_sel", led_row, 8'h08);
        check("abort_sb", sb.size(), 1);
        if (sb.size() != 0) begin
            abort_e = sb.pop_front();
            check("abort_raddr", abort_e.addr, 3'd3);
        end
        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("enable_drop",
              {row_idx, led_row, led_col_r, led_col_g, led_col_b, fb.fb_rd_en},
              {3'd0, 8'h00, 24'hFFFFFF, 1'b0});
        repeat (3) @(negedge clk);
        sb.delete();
        exp_row = 0;
        enable = 1'b1;
        run_rows(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
